// File: rtl/alu_pkg.sv
// Shared types and constants for the sequential ALU / multiply-divide unit.
// Covers the handshake states, ALUOp and funct3 encodings, and operand signedness selection.
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MUL  = 2'b01,
        DIV  = 2'b10,
        DONE = 2'b11
    } state_e;

    typedef enum logic [1:0] {
        MD_MUL_LO = 2'b00,
        MD_MUL_HI = 2'b01,
        MD_DIV_Q  = 2'b10,
        MD_DIV_R  = 2'b11
    } md_op_e;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    // Bit 1: operand a is signed, bit 0: operand b is signed.
    localparam logic [1:0] SGN_UU = 2'b00;
    localparam logic [1:0] SGN_SU = 2'b10;
    localparam logic [1:0] SGN_SS = 2'b11;

    function automatic logic [1:0] m_sign_sel(input logic [2:0] f3);
        logic [1:0] sel;
        case (f3)
            F3_MUL, F3_MULH, F3_DIV, F3_REM: sel = SGN_SS;
            F3_MULHSU:                       sel = SGN_SU;
            default:                         sel = SGN_UU;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative multiply/divide engine: one shift-add or restoring-divide step per cycle for WIDTH cycles.
// Works on magnitudes; the sign fix is applied to the result presented alongside done.
import alu_pkg::*;

module alu_muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  md_op_e           op,
    input  logic [WIDTH-1:0] mag_a,
    input  logic [WIDTH-1:0] mag_b,
    input  logic             neg,
    output logic             done,
    output logic [WIDTH-1:0] result
);
    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

    logic [2*WIDTH-1:0] acc_r;
    logic [WIDTH-1:0]   opb_r;
    logic [SHW-1:0]     cnt_r;
    logic               run_r;
    md_op_e             op_r;
    logic               neg_r;

    logic [WIDTH:0]     mul_sum_s;
    logic [WIDTH:0]     div_shift_s;
    logic [WIDTH:0]     div_trial_s;
    logic [2*WIDTH-1:0] acc_nx_s;
    logic [2*WIDTH-1:0] prod_fix_s;
    logic [WIDTH-1:0]   result_s;

    // One iteration step; acc holds {partial product, multiplier} or {remainder, quotient}
    always_comb begin
        mul_sum_s   = {1'b0, acc_r[2*WIDTH-1:WIDTH]}
                    + (acc_r[0] ? {1'b0, opb_r} : {(WIDTH+1){1'b0}});
        div_shift_s = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
        div_trial_s = div_shift_s - {1'b0, opb_r};
        if (op_r == MD_MUL_LO || op_r == MD_MUL_HI) begin
            acc_nx_s = {mul_sum_s, acc_r[WIDTH-1:1]};
        end else if (div_trial_s[WIDTH]) begin
            acc_nx_s = {div_shift_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
        end else begin
            acc_nx_s = {div_trial_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
        end
    end

    // Sign fix and result selection from the final accumulator value
    always_comb begin
        prod_fix_s = neg_r ? ({(2*WIDTH){1'b0}} - acc_nx_s) : acc_nx_s;
        case (op_r)
            MD_MUL_LO: result_s = prod_fix_s[WIDTH-1:0];
            MD_MUL_HI: result_s = prod_fix_s[2*WIDTH-1:WIDTH];
            MD_DIV_Q:  result_s = neg_r ? ({WIDTH{1'b0}} - acc_nx_s[WIDTH-1:0])
                                        : acc_nx_s[WIDTH-1:0];
            MD_DIV_R:  result_s = neg_r ? ({WIDTH{1'b0}} - acc_nx_s[2*WIDTH-1:WIDTH])
                                        : acc_nx_s[2*WIDTH-1:WIDTH];
            default:   result_s = {WIDTH{1'b0}};
        endcase
    end

    // Iteration state: load on start, step while running
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_r <= {(2*WIDTH){1'b0}};
            opb_r <= {WIDTH{1'b0}};
            cnt_r <= {SHW{1'b0}};
            run_r <= 1'b0;
            op_r  <= MD_MUL_LO;
            neg_r <= 1'b0;
        end else if (start) begin
            acc_r <= {{WIDTH{1'b0}}, mag_a};
            opb_r <= mag_b;
            cnt_r <= {SHW{1'b0}};
            run_r <= 1'b1;
            op_r  <= op;
            neg_r <= neg;
        end else if (run_r) begin
            acc_r <= acc_nx_s;
            cnt_r <= cnt_r + {{(SHW-1){1'b0}}, 1'b1};
            run_r <= (cnt_r != CNT_LAST);
        end else begin
            acc_r <= acc_r;
        end
    end

    assign done   = run_r && (cnt_r == CNT_LAST);
    assign result = result_s;

endmodule

// File: rtl/alu_mdu_seq.sv
// Sequential RV32I/M execution unit with valid/ready handshakes on both sides.
// Base ops complete in one cycle; M ops iterate in alu_muldiv_iter for WIDTH cycles.
import alu_pkg::*;

module alu_mdu_seq #(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       ALUOp,
    input  logic [2:0]       funct3,
    input  logic             funct7b5,
    input  logic             funct7b0,
    input  logic             opb5,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_out,
    output logic             zero,
    output logic             busy
);
    state_e           state_r, state_nx_s;
    logic             in_ready_r, out_valid_r, busy_r, zero_r;
    logic [WIDTH-1:0] alu_out_r;

    logic [WIDTH-1:0] base_s, res_s, mag_a_s, mag_b_s, md_result_s;
    logic [1:0]       sgn_s;
    logic             is_m_s, a_neg_s, b_neg_s, md_neg_s, start_s, load_s, md_done_s;
    md_op_e           md_op_s;

    // Base RV32I result; ALUOp 00/01 bypass funct3 entirely
    always_comb begin
        base_s = a + b;
        case (ALUOp)
            ALU_ADD: base_s = a + b;
            ALU_SUB: base_s = a - b;
            ALU_FUNCT: begin
                case (funct3)
                    F3_ADD:  base_s = (funct7b5 && opb5) ? (a - b) : (a + b);
                    F3_SLL:  base_s = a << b[SHW-1:0];
                    F3_SLT:  base_s = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
                    F3_SLTU: base_s = {{(WIDTH-1){1'b0}}, (a < b)};
                    F3_XOR:  base_s = a ^ b;
                    F3_SR:   base_s = funct7b5 ? $unsigned($signed(a) >>> b[SHW-1:0])
                                               : (a >> b[SHW-1:0]);
                    F3_OR:   base_s = a | b;
                    F3_AND:  base_s = a & b;
                    default: base_s = a + b;
                endcase
            end
            default: base_s = a + b;
        endcase
    end

    // M-op decode: magnitudes, engine op and final sign of the selected result
    always_comb begin
        is_m_s  = (ALUOp == ALU_FUNCT) && opb5 && funct7b0;
        sgn_s   = m_sign_sel(funct3);
        a_neg_s = sgn_s[1] && a[WIDTH-1];
        b_neg_s = sgn_s[0] && b[WIDTH-1];
        mag_a_s = a_neg_s ? ({WIDTH{1'b0}} - a) : a;
        mag_b_s = b_neg_s ? ({WIDTH{1'b0}} - b) : b;
        if (!funct3[2]) begin
            md_op_s  = (funct3[1:0] == 2'b00) ? MD_MUL_LO : MD_MUL_HI;
            md_neg_s = a_neg_s ^ b_neg_s;
        end else if (!funct3[1]) begin
            // Division by zero keeps the all-ones quotient unsigned
            md_op_s  = MD_DIV_Q;
            md_neg_s = (a_neg_s ^ b_neg_s) && (b != {WIDTH{1'b0}});
        end else begin
            md_op_s  = MD_DIV_R;
            md_neg_s = a_neg_s;
        end
    end

    alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .clk    (clk),
        .reset  (reset),
        .start  (start_s),
        .op     (md_op_s),
        .mag_a  (mag_a_s),
        .mag_b  (mag_b_s),
        .neg    (md_neg_s),
        .done   (md_done_s),
        .result (md_result_s)
    );

    // Handshake FSM next state and result load strobe
    always_comb begin
        state_nx_s = state_r;
        start_s    = 1'b0;
        load_s     = 1'b0;
        res_s      = base_s;
        case (state_r)
            IDLE: begin
                if (in_valid && is_m_s) begin
                    start_s    = 1'b1;
                    state_nx_s = funct3[2] ? DIV : MUL;
                end else if (in_valid) begin
                    load_s     = 1'b1;
                    state_nx_s = DONE;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            MUL, DIV: begin
                res_s = md_result_s;
                if (md_done_s) begin
                    load_s     = 1'b1;
                    state_nx_s = DONE;
                end else begin
                    state_nx_s = state_r;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = DONE;
                end
            end
            default: state_nx_s = IDLE;
        endcase
    end

    // State and registered handshake/result outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            alu_out_r   <= {WIDTH{1'b0}};
            zero_r      <= 1'b1;
        end else begin
            state_r     <= state_nx_s;
            in_ready_r  <= (state_nx_s == IDLE);
            out_valid_r <= (state_nx_s == DONE);
            busy_r      <= (state_nx_s == MUL) || (state_nx_s == DIV);
            if (load_s) begin
                alu_out_r <= res_s;
                zero_r    <= (res_s == {WIDTH{1'b0}});
            end else begin
                alu_out_r <= alu_out_r;
                zero_r    <= zero_r;
            end
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign alu_out   = alu_out_r;
    assign zero      = zero_r;

endmodule

// File: tb/tb_alu_mdu_seq.sv
// Self-checking bench for alu_mdu_seq: directed cases plus randomized ops against an arithmetic model.
module tb_alu_mdu_seq;
    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid, in_ready, out_valid, out_ready, zero, busy;
    logic [W-1:0]  a, b, alu_out;
    logic [1:0]    ALUOp;
    logic [2:0]    funct3;
    logic          funct7b5, funct7b0, opb5;
    int            checks = 0;
    int            errors = 0;

    alu_mdu_seq #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .ALUOp(ALUOp), .funct3(funct3), .funct7b5(funct7b5),
        .funct7b0(funct7b0), .opb5(opb5), .out_valid(out_valid), .out_ready(out_ready),
        .alu_out(alu_out), .zero(zero), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Arithmetic reference built from the RISC-V definitions using 64-bit integers
    function automatic logic [31:0] ref_model(input logic [31:0] x, input logic [31:0] y,
                                              input logic [1:0] op, input logic [2:0] f3,
                                              input logic f5, input logic f0, input logic ob5);
        logic signed [63:0] p;
        logic [63:0]        pu;
        logic [31:0]        r;
        longint             sx, sy;
        logic               ovf;
        sx  = longint'($signed(x));
        sy  = longint'($signed(y));
        ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
        r   = x + y;
        if (op == 2'b01) begin
            r = x - y;
        end else if (op == 2'b10 && ob5 && f0) begin
            case (f3)
                3'd0: begin p = sx * sy; r = p[31:0]; end
                3'd1: begin p = sx * sy; r = p[63:32]; end
                3'd2: begin p = sx * longint'({32'd0, y}); r = p[63:32]; end
                3'd3: begin pu = {32'd0, x} * {32'd0, y}; r = pu[63:32]; end
                3'd4: r = (y == 32'd0) ? 32'hFFFF_FFFF : (ovf ? x : 32'(sx / sy));
                3'd5: r = (y == 32'd0) ? 32'hFFFF_FFFF : x / y;
                3'd6: r = (y == 32'd0) ? x : (ovf ? 32'd0 : 32'(sx % sy));
                default: r = (y == 32'd0) ? x : x % y;
            endcase
        end else if (op == 2'b10) begin
            case (f3)
                3'd0: r = (f5 && ob5) ? x - y : x + y;
                3'd1: r = x << y[4:0];
                3'd2: r = (sx < sy) ? 32'd1 : 32'd0;
                3'd3: r = (x < y) ? 32'd1 : 32'd0;
                3'd4: r = x ^ y;
                3'd5: r = f5 ? 32'($signed(x) >>> y[4:0]) : x >> y[4:0];
                3'd6: r = x | y;
                default: r = x & y;
            endcase
        end
        return r;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'd1;
            default: return 32'($urandom);
        endcase
    endfunction

    // Issue one op at posedge+1 in IDLE with out_ready=1 and check latency, busy span and result
    task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tb,
                          input logic [1:0] op, input logic [2:0] f3, input logic f5,
                          input logic f0, input logic ob5, input logic [31:0] exp);
        int   lat, busy_n, exp_lat;
        logic is_m;
        is_m    = (op == 2'b10) && ob5 && f0;
        exp_lat = is_m ? W + 1 : 1;
        a = ta; b = tb; ALUOp = op; funct3 = f3; funct7b5 = f5; funct7b0 = f0; opb5 = ob5;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({tag, ".in_ready_busy"}, {31'd0, in_ready}, 32'd0);
        lat = 1;
        busy_n = 0;
        while (out_valid !== 1'b1 && lat < 100) begin
            if (busy === 1'b1) busy_n++;
            @(posedge clk); #1;
            lat++;
        end
        check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
        check({tag, ".busy_cycles"}, 32'(busy_n), is_m ? 32'(W) : 32'd0);
        check({tag, ".alu_out"}, alu_out, exp);
        check({tag, ".zero"}, {31'd0, zero}, {31'd0, (exp == 32'd0)});
        @(posedge clk); #1;
        check({tag, ".back_to_idle"}, {30'd0, in_ready, out_valid}, 32'd2);
    endtask

    initial begin
        logic [31:0] held;
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = 32'd0; b = 32'd0; ALUOp = 2'b00; funct3 = 3'd0;
        funct7b5 = 1'b0; funct7b0 = 1'b0; opb5 = 1'b0;
        #12;
        check("reset.in_ready", {31'd0, in_ready}, 32'd1);
        check("reset.out_valid", {31'd0, out_valid}, 32'd0);
        check("reset.alu_out", alu_out, 32'd0);
        check("reset.zero_busy", {30'd0, zero, busy}, 32'd2);
        reset = 1'b1;
        @(posedge clk); #1;

        run_op("add", 32'd5, 32'd7, 2'b00, 3'd0, 1'b0, 1'b0, 1'b0, 32'd12);
        run_op("sub", 32'd7, 32'd7, 2'b01, 3'd0, 1'b0, 1'b0, 1'b0, 32'd0);
        run_op("sra", 32'h8000_0000, 32'd4, 2'b10, 3'd5, 1'b1, 1'b0, 1'b1, 32'hF800_0000);
        run_op("srl", 32'h8000_0000, 32'd4, 2'b10, 3'd5, 1'b0, 1'b0, 1'b1, 32'h0800_0000);
        run_op("mulh", 32'hFFFF_FFFE, 32'd3, 2'b10, 3'd1, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF);
        run_op("mul", 32'hFFFF_FFFE, 32'd3, 2'b10, 3'd0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFA);
        run_op("div0", 32'd7, 32'd0, 2'b10, 3'd4, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF);
        run_op("rem0", 32'd7, 32'd0, 2'b10, 3'd6, 1'b0, 1'b1, 1'b1, 32'd7);
        run_op("divovf", 32'h8000_0000, 32'hFFFF_FFFF, 2'b10, 3'd4, 1'b0, 1'b1, 1'b1, 32'h8000_0000);
        run_op("removf", 32'h8000_0000, 32'hFFFF_FFFF, 2'b10, 3'd6, 1'b0, 1'b1, 1'b1, 32'd0);
        run_op("divneg", 32'hFFFF_FFF9, 32'd2, 2'b10, 3'd4, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFD);
        run_op("remneg", 32'hFFFF_FFF9, 32'd2, 2'b10, 3'd6, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF);

        // Back-pressure: result must hold and new requests must be ignored
        out_ready = 1'b0;
        a = 32'h0F0F_0000; b = 32'h00FF_00FF; ALUOp = 2'b10; funct3 = 3'd4;
        funct7b5 = 1'b0; funct7b0 = 1'b0; opb5 = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        held = 32'h0FF0_00FF;
        check("hold.first_valid", {31'd0, out_valid}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            a = 32'($urandom); b = 32'($urandom); in_valid = 1'b1;
            @(posedge clk); #1;
            check("hold.out_valid", {31'd0, out_valid}, 32'd1);
            check("hold.alu_out", alu_out, held);
            check("hold.in_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        check("hold.release", {30'd0, in_ready, out_valid}, 32'd2);

        // Asynchronous reset in the middle of a divu
        a = 32'd1000; b = 32'd7; ALUOp = 2'b10; funct3 = 3'd5;
        funct7b5 = 1'b0; funct7b0 = 1'b1; opb5 = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        check("abort.busy_before", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        #1;
        check("abort.out_valid", {31'd0, out_valid}, 32'd0);
        check("abort.in_ready", {31'd0, in_ready}, 32'd1);
        check("abort.alu_out", alu_out, 32'd0);
        check("abort.zero_busy", {30'd0, zero, busy}, 32'd2);
        #9;
        reset = 1'b1;
        run_op("after_reset", 32'd1, 32'd1, 2'b00, 3'd0, 1'b0, 1'b0, 1'b0, 32'd2);

        for (int i = 0; i < 40; i++) begin
            logic [31:0] ra, rb;
            logic [1:0]  rop;
            logic [2:0]  rf3;
            logic        rf5, rf0, rob5;
            ra  = pick();
            rb  = pick();
            rf3 = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 2) == 0) begin
                rop = 2'b10; rob5 = 1'b1; rf0 = 1'b1; rf5 = 1'b0;
            end else begin
                rop  = 2'($urandom_range(0, 2));
                rob5 = 1'($urandom_range(0, 1));
                rf5  = 1'($urandom_range(0, 1));
                rf0  = (rop == 2'b10 && rob5) ? 1'b0 : 1'($urandom_range(0, 1));
            end
            run_op($sformatf("rnd%0d", i), ra, rb, rop, rf3, rf5, rf0, rob5,
                   ref_model(ra, rb, rop, rf3, rf5, rf0, rob5));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
